// File: rtl/sigmoid_alu_accumulator.sv
// Neuron dot-product accumulator: sums signed products onto a bias with saturation,
// then offers a scaled, saturated result over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for start; no products consumed
// ACCUM   | accepting product beats until the in_last beat
// HOLD    | result presented until downstream takes it
module sigmoid_alu_accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 4,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [7:0]           i_bias,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [7:0]           i_product,
  input  logic                 i_in_last,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [OUT_WIDTH-1:0] o_out_data,
  output logic                 o_ovf,
  output logic [CNT_WIDTH-1:0] o_term_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [CNT_WIDTH-1:0]         r_cnt;
  logic                         r_ovf;

  logic                         w_accept;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic                         w_sat_hit;
  logic signed [ACC_WIDTH-1:0]  w_acc_sat;
  logic signed [ACC_WIDTH-1:0]  w_shift;
  logic [OUT_WIDTH-1:0]         w_out_sat;

  assign w_accept = (r_state == S_ACCUM) && i_in_valid;

  // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
  assign w_sum     = {r_acc[ACC_WIDTH-1], r_acc}
                   + {{(ACC_WIDTH+1-8){i_product[7]}}, i_product};
  assign w_sat_hit = w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1];
  assign w_acc_sat = !w_sat_hit          ? w_sum[ACC_WIDTH-1:0] :
                     w_sum[ACC_WIDTH]    ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                           {1'b0, {(ACC_WIDTH-1){1'b1}}};

  // Result fits when every bit above the output sign bit matches it.
  assign w_shift   = r_acc >>> SHIFT;
  assign w_out_sat = ((&w_shift[ACC_WIDTH-1:OUT_WIDTH-1]) ||
                      !(|w_shift[ACC_WIDTH-1:OUT_WIDTH-1]))
                     ? w_shift[OUT_WIDTH-1:0]
                     : (w_shift[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                             : {1'b0, {(OUT_WIDTH-1){1'b1}}});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_out_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        o_in_ready = 1'b1;
        if (i_in_valid && i_in_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        o_out_valid = 1'b1;
        o_out_data  = w_out_sat;
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_IDLE && i_start) begin
      r_acc <= {{(ACC_WIDTH-8){i_bias[7]}}, i_bias};
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_sat;
      r_ovf <= r_ovf | w_sat_hit;
      if (r_cnt != {CNT_WIDTH{1'b1}}) r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_ovf      = r_ovf;
  assign o_term_cnt = r_cnt;

endmodule

// File: tb/tb_sigmoid_alu_accumulator.sv
// Directed bench for sigmoid_alu_accumulator: an integer reference model pushes expected
// results into a queue on each in_last beat; they are popped when the result is taken.
module tb_sigmoid_alu_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bias;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] product;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       ovf;
  logic [9:0] term_cnt;

  sigmoid_alu_accumulator dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_bias      (bias),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_product   (product),
    .i_in_last   (in_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_ovf       (ovf),
    .o_term_cnt  (term_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
    logic [9:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_acc;
  int   m_cnt;
  bit   m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_out(input int a);
    int s;
    s = a >>> 4;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  task automatic start_neuron(input int b);
    start = 1'b1;
    bias  = b[7:0];
    @(negedge clk);
    start = 1'b0;
    m_acc = b;
    m_cnt = 0;
    m_ovf = 1'b0;
    check("start in_ready", {31'd0, in_ready}, 32'd1);
    check("start term_cnt", {22'd0, term_cnt}, 32'd0);
    check("start ovf", {31'd0, ovf}, 32'd0);
  endtask

  task automatic beat(input int p, input bit last);
    exp_t e;
    in_valid = 1'b1;
    product  = p[7:0];
    in_last  = last;
    check("beat in_ready", {31'd0, in_ready}, 32'd1);
    m_acc = m_acc + p;
    if (m_acc > 32767)  begin m_acc = 32767;  m_ovf = 1'b1; end
    if (m_acc < -32768) begin m_acc = -32768; m_ovf = 1'b1; end
    if (m_cnt < 1023) m_cnt++;
    if (last) begin
      e.data = exp_out(m_acc);
      e.ovf  = m_ovf;
      e.cnt  = m_cnt[9:0];
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input string tag, input bit with_start);
    exp_t e;
    for (int k = 0; k < 10 && out_valid !== 1'b1; k++) @(negedge clk);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " queue"}, q.size(), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, " out_data"}, {24'd0, out_data}, {24'd0, e.data});
      check({tag, " ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
      check({tag, " term_cnt"}, {22'd0, term_cnt}, {22'd0, e.cnt});
    end
    check({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    start     = with_start;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " idle in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    exp_t held;
    rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0; product = '0;
    in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_data", {24'd0, out_data}, 32'd0);
    check("rst ovf", {31'd0, ovf}, 32'd0);
    check("rst term_cnt", {22'd0, term_cnt}, 32'd0);
    rst = 1'b0;

    // Product offered in IDLE must not be consumed.
    in_valid = 1'b1; product = 8'd5; in_last = 1'b1;
    @(negedge clk);
    check("idle no ready", {31'd0, in_ready}, 32'd0);
    check("idle no valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0; in_last = 1'b0;

    // 1: three products of 105
    start_neuron(0);
    beat(105, 0); beat(105, 0); beat(105, 1);
    check("t1 latency", {31'd0, out_valid}, 32'd1);
    collect("t1", 1'b0);

    // 2: floor of a small negative sum
    start_neuron(0);
    beat(105, 0); beat(-120, 1);
    collect("t2", 1'b0);

    // 3: positive then negative saturation
    start_neuron(0);
    for (int i = 0; i < 320; i++) beat(105, i == 319);
    collect("t3pos", 1'b0);
    start_neuron(0);
    for (int i = 0; i < 400; i++) beat(-120, i == 399);
    collect("t3neg", 1'b0);

    // 4: HOLD stable under back-pressure, start ignored
    start_neuron(7);
    beat(50, 0); beat(-3, 1);
    held = q[0];
    for (int i = 0; i < 5; i++) begin
      check("t4 hold valid", {31'd0, out_valid}, 32'd1);
      check("t4 hold data", {24'd0, out_data}, {24'd0, held.data});
      check("t4 hold in_ready", {31'd0, in_ready}, 32'd0);
      check("t4 hold cnt", {22'd0, term_cnt}, 32'd2);
      start = (i == 2);
      bias  = 8'd99;
      @(negedge clk);
      start = 1'b0;
    end
    collect("t4", 1'b0);

    // Single-term zero neuron; start coincident with out_ready is not honoured.
    start_neuron(0);
    beat(0, 1);
    collect("t4b", 1'b1);
    @(negedge clk);
    check("t4b still idle", {31'd0, in_ready}, 32'd0);

    // 5: reset mid-ACCUM discards the partial sum
    start_neuron(10);
    beat(20, 0); beat(30, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 in_ready", {31'd0, in_ready}, 32'd0);
    check("t5 out_valid", {31'd0, out_valid}, 32'd0);
    check("t5 term_cnt", {22'd0, term_cnt}, 32'd0);
    check("t5 out_data", {24'd0, out_data}, 32'd0);
    start_neuron(-3);
    beat(0, 1);
    collect("t5", 1'b0);

    // 6: gapped input
    start_neuron(0);
    beat(8, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t6 gap in_ready", {31'd0, in_ready}, 32'd1);
      check("t6 gap cnt", {22'd0, term_cnt}, 32'd1);
    end
    beat(8, 1);
    collect("t6", 1'b0);

    check("queue drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
